// File: rtl/rj_sequencer.sv
// rj_sequencer: controller for the 16-entry rj memory of one MSDAP channel.
// Loads a full rj table from the input deserializer, then sweeps the table
// for the filter datapath under a valid/ack handshake.
module rj_sequencer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int NUM_RJ = 16
) (
   input  logic              Sclk,
   input  logic              Reset,
   input  logic              load_start,
   input  logic              word_valid,
   input  logic [DATA_W-1:0] word_in,
   input  logic              compute_start,
   input  logic              rj_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              write_enable,
   output logic [ADDR_W-1:0] rjwrite,
   output logic [DATA_W-1:0] wdata,
   output logic              read_enable,
   output logic [ADDR_W-1:0] rjread,
   output logic              rj_valid,
   output logic [DATA_W-1:0] rj_data,
   output logic              rj_last,
   output logic              load_done,
   output logic              sweep_done
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READY,
      READ
   } state_t;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_RJ - 1);

   state_t          state;
   logic [ADDR_W:0] wcnt;
   logic [ADDR_W:0] rcnt;

   // Sequencer FSM: all control outputs are registered here; a load_start
   // always wins and restarts the table load from address 0.
   always_ff @(posedge Sclk) begin
      if (Reset) begin
         state        <= IDLE;
         wcnt         <= '0;
         rcnt         <= '0;
         write_enable <= 1'b0;
         rjwrite      <= '0;
         wdata        <= '0;
         read_enable  <= 1'b0;
         rjread       <= '0;
         rj_valid     <= 1'b0;
         load_done    <= 1'b0;
         sweep_done   <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         sweep_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (load_start) begin
                  state     <= LOAD;
                  wcnt      <= '0;
                  load_done <= 1'b0;
               end
            end
            LOAD: begin
               if (load_start) begin
                  wcnt      <= '0;
                  load_done <= 1'b0;
               end else if (write_enable && ({1'b0, rjwrite} == LAST_IDX)) begin
                  state     <= READY;
                  load_done <= 1'b1;
               end else if (word_valid && (wcnt <= LAST_IDX)) begin
                  write_enable <= 1'b1;
                  rjwrite      <= wcnt[ADDR_W-1:0];
                  wdata        <= word_in;
                  wcnt         <= wcnt + 1'b1;
               end
            end
            READY: begin
               if (load_start) begin
                  state     <= LOAD;
                  wcnt      <= '0;
                  load_done <= 1'b0;
               end else if (compute_start) begin
                  state       <= READ;
                  rcnt        <= '0;
                  rjread      <= '0;
                  read_enable <= 1'b1;
                  rj_valid    <= 1'b1;
               end
            end
            READ: begin
               if (load_start) begin
                  state       <= LOAD;
                  wcnt        <= '0;
                  rcnt        <= '0;
                  rjread      <= '0;
                  read_enable <= 1'b0;
                  rj_valid    <= 1'b0;
                  load_done   <= 1'b0;
               end else if (rj_valid && rj_ack) begin
                  if (rcnt == LAST_IDX) begin
                     state       <= READY;
                     rcnt        <= '0;
                     rjread      <= '0;
                     read_enable <= 1'b0;
                     rj_valid    <= 1'b0;
                     sweep_done  <= 1'b1;
                  end else begin
                     rcnt   <= rcnt + 1'b1;
                     rjread <= rjread + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The memory is combinational, so data is forwarded straight through and
   // gated to zero whenever no entry is being offered.
   always_comb begin
      rj_data = rj_valid ? mem_rdata : '0;
      rj_last = rj_valid && (rcnt == LAST_IDX);
   end

endmodule

// File: tb/tb_rj_sequencer.sv
// tb_rj_sequencer: directed testbench for rj_sequencer with a small
// combinational-read memory model standing in for the rj memory.
module tb_rj_sequencer;

   logic        Sclk = 1'b0;
   logic        Reset;
   logic        load_start;
   logic        word_valid;
   logic [15:0] word_in;
   logic        compute_start;
   logic        rj_ack;
   logic [15:0] mem_rdata;
   logic        write_enable;
   logic [3:0]  rjwrite;
   logic [15:0] wdata;
   logic        read_enable;
   logic [3:0]  rjread;
   logic        rj_valid;
   logic [15:0] rj_data;
   logic        rj_last;
   logic        load_done;
   logic        sweep_done;

   logic [15:0] mem [0:15];

   int assertCount = 0;
   int failCount   = 0;

   rj_sequencer #(.DATA_W(16), .ADDR_W(4), .NUM_RJ(16)) dut (
      .Sclk          (Sclk),
      .Reset         (Reset),
      .load_start    (load_start),
      .word_valid    (word_valid),
      .word_in       (word_in),
      .compute_start (compute_start),
      .rj_ack        (rj_ack),
      .mem_rdata     (mem_rdata),
      .write_enable  (write_enable),
      .rjwrite       (rjwrite),
      .wdata         (wdata),
      .read_enable   (read_enable),
      .rjread        (rjread),
      .rj_valid      (rj_valid),
      .rj_data       (rj_data),
      .rj_last       (rj_last),
      .load_done     (load_done),
      .sweep_done    (sweep_done)
   );

   // Free-running system clock, 10 time units per period.
   always #5 Sclk = ~Sclk;

   // Clear the memory model once at start-up.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
   end

   // Memory model: synchronous write, combinational read.
   always @(posedge Sclk) begin
      if (write_enable) mem[rjwrite] <= wdata;
   end

   assign mem_rdata = mem[rjread];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle worth of inputs, let the DUT clock them in, then settle.
   task automatic applyStimulus(input logic ls, input logic wv, input logic [15:0] wi,
                                input logic cs, input logic ack);
      load_start    = ls;
      word_valid    = wv;
      word_in       = wi;
      compute_start = cs;
      rj_ack        = ack;
      @(posedge Sclk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".write_enable"}, 32'(write_enable), 32'd0);
      checkOutput({tag, ".rjwrite"},      32'(rjwrite),      32'd0);
      checkOutput({tag, ".wdata"},        32'(wdata),        32'd0);
      checkOutput({tag, ".read_enable"},  32'(read_enable),  32'd0);
      checkOutput({tag, ".rjread"},       32'(rjread),       32'd0);
      checkOutput({tag, ".rj_valid"},     32'(rj_valid),     32'd0);
      checkOutput({tag, ".rj_data"},      32'(rj_data),      32'd0);
      checkOutput({tag, ".rj_last"},      32'(rj_last),      32'd0);
      checkOutput({tag, ".load_done"},    32'(load_done),    32'd0);
      checkOutput({tag, ".sweep_done"},   32'(sweep_done),   32'd0);
   endtask

   // Directed test sequence.
   initial begin
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkAllZero("por");
      Reset = 1'b0;

      $display("[TB] load 0x0001..0x0010 back to back");
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("load1.start_we", 32'(write_enable), 32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 16'(i + 1), 1'b0, 1'b0);
         checkOutput($sformatf("load1.we[%0d]", i),    32'(write_enable), 32'd1);
         checkOutput($sformatf("load1.addr[%0d]", i),  32'(rjwrite),      32'(i));
         checkOutput($sformatf("load1.wdata[%0d]", i), 32'(wdata),        32'(i + 1));
         checkOutput($sformatf("load1.done[%0d]", i),  32'(load_done),    32'd0);
         checkOutput($sformatf("load1.re[%0d]", i),    32'(read_enable),  32'd0);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("load1.done_after", 32'(load_done),    32'd1);
      checkOutput("load1.we_after",   32'(write_enable), 32'd0);
      applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
      checkOutput("load1.stray_word", 32'(write_enable), 32'd0);

      $display("[TB] sweep with ack held high");
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("sweep1.valid[%0d]", i), 32'(rj_valid),     32'd1);
         checkOutput($sformatf("sweep1.re[%0d]", i),    32'(read_enable),  32'd1);
         checkOutput($sformatf("sweep1.addr[%0d]", i),  32'(rjread),       32'(i));
         checkOutput($sformatf("sweep1.data[%0d]", i),  32'(rj_data),      32'(i + 1));
         checkOutput($sformatf("sweep1.last[%0d]", i),  32'(rj_last),      32'(i == 15));
         checkOutput($sformatf("sweep1.sd[%0d]", i),    32'(sweep_done),   32'd0);
         checkOutput($sformatf("sweep1.we[%0d]", i),    32'(write_enable), 32'd0);
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      end
      checkOutput("sweep1.sweep_done", 32'(sweep_done),  32'd1);
      checkOutput("sweep1.valid_end",  32'(rj_valid),    32'd0);
      checkOutput("sweep1.re_end",     32'(read_enable), 32'd0);
      checkOutput("sweep1.data_end",   32'(rj_data),     32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("sweep1.sd_pulse", 32'(sweep_done), 32'd0);
      checkOutput("sweep1.idle_vld", 32'(rj_valid),   32'd0);

      $display("[TB] sweep with ack withheld at index 5");
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("sweep2.addr[%0d]", i), 32'(rjread), 32'(i));
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      end
      for (int h = 0; h < 3; h++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
         checkOutput($sformatf("sweep2.hold_addr[%0d]", h),  32'(rjread),   32'd5);
         checkOutput($sformatf("sweep2.hold_data[%0d]", h),  32'(rj_data),  32'd6);
         checkOutput($sformatf("sweep2.hold_valid[%0d]", h), 32'(rj_valid), 32'd1);
      end
      for (int i = 5; i < 16; i++) begin
         checkOutput($sformatf("sweep2.addr[%0d]", i), 32'(rjread),  32'(i));
         checkOutput($sformatf("sweep2.data[%0d]", i), 32'(rj_data), 32'(i + 1));
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      end
      checkOutput("sweep2.sweep_done", 32'(sweep_done), 32'd1);

      $display("[TB] abort sweep at index 9, reload with gaps");
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("abort.addr9", 32'(rjread), 32'd9);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("abort.valid", 32'(rj_valid),    32'd0);
      checkOutput("abort.re",    32'(read_enable), 32'd0);
      checkOutput("abort.done",  32'(load_done),   32'd0);
      checkOutput("abort.sd",    32'(sweep_done),  32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
         checkOutput($sformatf("load2.we[%0d]", i),    32'(write_enable), 32'd1);
         checkOutput($sformatf("load2.addr[%0d]", i),  32'(rjwrite),      32'(i));
         checkOutput($sformatf("load2.wdata[%0d]", i), 32'(wdata),        32'h0100 + 32'(i));
         checkOutput($sformatf("load2.done[%0d]", i),  32'(load_done),    32'd0);
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
         checkOutput($sformatf("load2.gap_a[%0d]", i),  32'(write_enable), 32'd0);
         checkOutput($sformatf("load2.gap_done[%0d]", i), 32'(load_done),  32'(i == 15));
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
         checkOutput($sformatf("load2.gap_b[%0d]", i),  32'(write_enable), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      checkOutput("load2.stray_word", 32'(write_enable), 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("sweep3.data[%0d]", i), 32'(rj_data), 32'h0100 + 32'(i));
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      end
      checkOutput("sweep3.sweep_done", 32'(sweep_done), 32'd1);

      $display("[TB] reset in the middle of a sweep");
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("midreset.addr3", 32'(rjread), 32'd3);
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      checkAllZero("midreset");
      Reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      checkOutput("idle.compute_ignored", 32'(rj_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
      checkOutput("idle.word_ignored", 32'(write_enable), 32'd0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
